// File: rtl/dccm_banked_mem.sv
// Word-interleaved banked data memory: dual-word reads, single-entry write buffer
// that defers conflicting writes and force-drains after STARVE_LIMIT blocked cycles.
module dccm_banked_mem #(
  parameter int NUM_BANKS    = 4,
  parameter int BANK_DEPTH   = 256,
  parameter int DATA_W       = 39,
  parameter int STARVE_LIMIT = 4,
  localparam int BANK_W      = $clog2(NUM_BANKS),
  localparam int IDX_W       = $clog2(BANK_DEPTH),
  localparam int ADDR_W      = BANK_W + IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr_lo,
  input  logic [ADDR_W-1:0] rd_addr_hi,
  output logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data_lo,
  output logic [DATA_W-1:0] rd_data_hi,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [15:0]       defer_cnt
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic                 rd_valid_q;
  logic [DATA_W-1:0]    rd_data_lo_q, rd_data_hi_q;
  logic                 buf_valid_q, buf_valid_d;
  logic [ADDR_W-1:0]    buf_addr_q, buf_addr_d;
  logic [DATA_W-1:0]    buf_data_q, buf_data_d;
  logic [STARVE_W-1:0]  starve_q, starve_d;
  logic                 force_drain_q, force_drain_d;
  logic [15:0]          defer_cnt_q, defer_cnt_d;

  logic [BANK_W-1:0]    bank_lo, bank_hi, bank_wr, bank_buf, wsel_bank;
  logic [IDX_W-1:0]     idx_lo, idx_hi, wsel_idx;
  logic [ADDR_W-1:0]    wsel_addr;
  logic [DATA_W-1:0]    wsel_data;
  logic [NUM_BANKS-1:0] rd_busy, bank_we;
  logic [NUM_BANKS-1:0][IDX_W-1:0]  bank_idx;
  logic [NUM_BANKS-1:0][DATA_W-1:0] bank_rdata;
  logic                 rd_acc, wr_acc, wr_conf, drain, do_write, defer_inc;
  logic                 fwd_lo, fwd_hi;

  assign bank_lo  = rd_addr_lo[BANK_W-1:0];
  assign bank_hi  = rd_addr_hi[BANK_W-1:0];
  assign idx_lo   = rd_addr_lo[ADDR_W-1:BANK_W];
  assign idx_hi   = rd_addr_hi[ADDR_W-1:BANK_W];
  assign bank_wr  = wr_addr[BANK_W-1:0];
  assign bank_buf = buf_addr_q[BANK_W-1:0];

  assign rd_ready = !freeze && !force_drain_q;
  assign wr_ready = !buf_valid_q;
  assign rd_acc   = rd_en && rd_ready;
  assign wr_acc   = wr_en && !buf_valid_q;

  always_comb begin
    rd_busy = '0;
    if (rd_acc) begin
      rd_busy[bank_lo] = 1'b1;
      rd_busy[bank_hi] = 1'b1;
    end
  end

  // A force-drain cycle accepts no read, so the buffer bank is always free then.
  assign wr_conf   = rd_busy[bank_wr];
  assign drain     = buf_valid_q && !rd_busy[bank_buf];
  assign do_write  = !rst && (drain || (wr_acc && !wr_conf));
  assign wsel_addr = buf_valid_q ? buf_addr_q : wr_addr;
  assign wsel_data = buf_valid_q ? buf_data_q : wr_data;
  assign wsel_bank = wsel_addr[BANK_W-1:0];
  assign wsel_idx  = wsel_addr[ADDR_W-1:BANK_W];

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_W-1:0] mem_q [BANK_DEPTH];

    assign bank_idx[b]   = rd_busy[b] ? ((bank_lo == BANK_W'(b)) ? idx_lo : idx_hi) : wsel_idx;
    assign bank_we[b]    = do_write && (wsel_bank == BANK_W'(b));
    assign bank_rdata[b] = mem_q[bank_idx[b]];

    always_ff @(posedge clk) begin
      if (bank_we[b]) mem_q[bank_idx[b]] <= wsel_data;
    end
  end

  assign fwd_lo = buf_valid_q && (buf_addr_q == rd_addr_lo);
  assign fwd_hi = buf_valid_q && (buf_addr_q == rd_addr_hi);

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    starve_d    = '0;
    defer_inc   = 1'b0;
    if (buf_valid_q) begin
      if (drain) begin
        buf_valid_d = 1'b0;
      end else begin
        defer_inc = 1'b1;
        starve_d  = starve_q + 1'b1;
      end
    end else if (wr_acc && wr_conf) begin
      buf_valid_d = 1'b1;
      buf_addr_d  = wr_addr;
      buf_data_d  = wr_data;
      defer_inc   = 1'b1;
    end
    force_drain_d = (starve_d == STARVE_W'(STARVE_LIMIT));
    defer_cnt_d   = (defer_inc && defer_cnt_q != 16'hFFFF) ? defer_cnt_q + 16'd1 : defer_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q    <= 1'b0;
      rd_data_lo_q  <= '0;
      rd_data_hi_q  <= '0;
      buf_valid_q   <= 1'b0;
      starve_q      <= '0;
      force_drain_q <= 1'b0;
      defer_cnt_q   <= '0;
    end else begin
      rd_valid_q <= rd_acc || (freeze && rd_valid_q);
      if (rd_acc) begin
        rd_data_lo_q <= fwd_lo ? buf_data_q : bank_rdata[bank_lo];
        rd_data_hi_q <= fwd_hi ? buf_data_q : bank_rdata[bank_hi];
      end
      buf_valid_q   <= buf_valid_d;
      starve_q      <= starve_d;
      force_drain_q <= force_drain_d;
      defer_cnt_q   <= defer_cnt_d;
    end
    buf_addr_q <= buf_addr_d;
    buf_data_q <= buf_data_d;
  end

  assign rd_valid   = rd_valid_q;
  assign rd_data_lo = rd_data_lo_q;
  assign rd_data_hi = rd_data_hi_q;
  assign defer_cnt  = defer_cnt_q;

endmodule

// File: doc/dccm_banked_mem.md
DCCM_BANKED_MEM -- requirements
Module: dccm_banked_mem

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 4, number of word-interleaved banks (power of 2, 2..8).
REQ-002 SHALL have parameter BANK_DEPTH, default 256, words per bank (power of 2).
REQ-003 SHALL have parameter DATA_W, default 39, word width (32 data + 7 ECC).
REQ-004 SHALL have parameter STARVE_LIMIT, default 4, consecutive blocked cycles before a forced write drain.
REQ-005 SHALL derive ADDR_W = log2(NUM_BANKS*BANK_DEPTH); bank = addr[log2(NUM_BANKS)-1:0], index = remaining upper bits.
REQ-006 clk  in  1  single clock; all state on rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 freeze  in  1  hold read outputs, block new reads.
REQ-009 rd_en  in  1  dual-word read request.
REQ-010 rd_addr_lo, rd_addr_hi  in  ADDR_W each  word addresses of the two reads.
REQ-011 rd_ready  out  1  read accepted when rd_en & rd_ready.
REQ-012 rd_valid  out  1  read data valid.
REQ-013 rd_data_lo, rd_data_hi  out  DATA_W each  read data.
REQ-014 wr_en, wr_addr, wr_data  in  1, ADDR_W, DATA_W  write request.
REQ-015 wr_ready  out  1  write accepted when wr_en & wr_ready.
REQ-016 defer_cnt  out  16  saturating count of cycles a write was deferred by read conflict.

Function
REQ-017 Storage SHALL be NUM_BANKS independent single-port arrays, each with one access (read or write) per cycle.
REQ-018 Accepted read SHALL assert rd_valid and rd_data_lo/hi exactly 1 cycle later; rd_valid otherwise 0 unless freeze holds it.
REQ-019 rd_addr_lo and rd_addr_hi in the same bank SHALL be legal only if equal; equal addresses use one access and return identical data.
REQ-020 rd_ready SHALL = !freeze & !force_drain.
REQ-021 freeze=1: rd_valid, rd_data_lo, rd_data_hi SHALL hold; writes and drains continue.
REQ-022 Write buffer SHALL be one entry (buf_valid, buf_addr, buf_data); wr_ready SHALL = !buf_valid.
REQ-023 Accepted write, buffer empty, bank not used by an accepted read this cycle: SHALL write the array that cycle.
REQ-024 Accepted write whose bank is used by an accepted read this cycle: SHALL load the buffer; defer_cnt increments.
REQ-025 buf_valid, bank not used by an accepted read: SHALL drain to the array and clear buf_valid that cycle.
REQ-026 buf_valid, bank used by an accepted read: buffer SHALL hold; defer_cnt increments; starve counter increments.
REQ-027 starve counter reaching STARVE_LIMIT SHALL set force_drain next cycle; that cycle no read is accepted, buffer drains, starve counter and force_drain clear.
REQ-028 Starve counter SHALL clear whenever buf_valid is 0.
REQ-029 Read ordering: a read accepted in cycle N SHALL return data of every write accepted in cycles < N, forwarding buf_data when buf_valid and buf_addr matches; a write accepted in cycle N is not visible to a read accepted in cycle N.
REQ-030 Forwarding SHALL apply independently to lo and hi.
REQ-031 defer_cnt SHALL saturate at 16'hFFFF.
REQ-032 Same-cycle drain and new write impossible (wr_ready=0 while buf_valid); write order SHALL match acceptance order.

Reset
REQ-033 rst SHALL clear rd_valid, rd_data_lo, rd_data_hi, buf_valid, starve counter, force_drain, defer_cnt to 0; wr_ready=1 and rd_ready=!freeze in the cycle after reset.
REQ-034 Array contents SHALL NOT be reset.
REQ-035 rst during a buffered write SHALL discard it without an array write.

Verification (NUM_BANKS=4, DATA_W=39, STARVE_LIMIT=4)
REQ-036 Write addr 0x05 data 0x12_3456_789A, idle; next cycle read lo=0x05 hi=0x06 -> one cycle later rd_valid=1, rd_data_lo=0x12_3456_789A.
REQ-037 Same cycle write addr 0x09 (bank 1) + read lo=0x01 (bank 1) -> defer_cnt=1, wr_ready=0 next cycle; read at 0x09 next cycle returns forwarded data.
REQ-038 Buffered write bank 2, reads hitting bank 2 every cycle -> 4 blocked cycles, then rd_ready=0 for one cycle, buffer drains, wr_ready=1 next cycle.
REQ-039 Read accepted, freeze=1 for 3 cycles with new rd_en -> rd_data unchanged, rd_ready=0, no new rd_valid pulse.
REQ-040 Buffered write then rst=1 -> buf_valid=0, defer_cnt=0, rd_valid=0; later read of that address returns pre-write contents.
REQ-041 Force defer_cnt to 0xFFFF via repeated conflicts -> stays 0xFFFF on further conflicts.
